instr_fetch_cached: RTL

Parametrised successor to the current instruction fetch stage. It holds the PC, selects PC+4 or a branch target, and reads instructions through an internal direct-mapped instruction cache. On a miss it runs a request/acknowledge refill from backing memory. It sits between the branch-resolution logic and the decode stage, and exposes hit and valid status.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/icache_dm_array.sv | 50 +++++
 rtl/instr_fetch_cached.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared definitions for the cached instruction fetch stage: FSM state
// encoding, instruction size and cache geometry helpers.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    localparam int INSTR_BYTES = 4;

    // Number of index bits for a direct-mapped cache with 'lines' lines.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: whatever address bits remain above index and byte offset.
    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines) - $clog2(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Storage for the direct-mapped instruction cache: per-line valid bit,
// tag and one data word. One synchronous write port, combinational read.
module icache_dm_array
    import ifetch_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data
);

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_r  [LINES];
    logic [DATA_W-1:0] data_r [LINES];

    // Valid bits: cleared by reset (which also blocks a coincident write), set on refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data payload: overwritten unconditionally on refill, never reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_r[wr_idx]  <= wr_tag;
            data_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_r[rd_idx];
    assign rd_data  = data_r[rd_idx];

endmodule

// File: rtl/instr_fetch_cached.sv
// Instruction fetch stage with an internal direct-mapped instruction cache.
// Holds the PC, selects PC+4 or a branch target, and refills missing lines
// from backing memory through a request/acknowledge handshake. Redirects
// arriving while a refill is in flight are held and applied once the line
// has been installed.
// Optional build macro ICACHE_STATS_EN adds hit_count / miss_count outputs.
module instr_fetch_cached
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                LINES    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcSrc,
    input  logic [ADDR_W-1:0] branchAddr,
    input  logic              stall,
    output logic [ADDR_W-1:0] adderOutput,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              valid,
    output logic              hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int                IDX_W      = idx_w(LINES);
    localparam int                TAG_W      = tag_w(ADDR_W, LINES);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   pc_r;
    logic                pend_r;
    logic [ADDR_W-1:0]   pend_tgt_r;

    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic                line_valid_s;
    logic [TAG_W-1:0]    line_tag_s;
    logic [DATA_W-1:0]   line_data_s;
    logic                hit_s;
    logic                mem_req_s;
    logic                fill_s;
    logic [ADDR_W-1:0]   branch_tgt_s;

    assign idx_s        = pc_r[IDX_W+1:2];
    assign tag_s        = pc_r[ADDR_W-1:IDX_W+2];
    assign branch_tgt_s = branchAddr & ALIGN_MASK;
    assign fill_s       = (state_r == ST_MISS) && mem_ack;

    icache_dm_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fill_s),
        .wr_idx   (idx_s),
        .wr_tag   (tag_s),
        .wr_data  (mem_rdata),
        .rd_idx   (idx_s),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state: a RUN miss starts a refill, ack installs, REFILL returns to RUN.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (hit_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_MISS;
                end
            end
            ST_MISS: begin
                if (mem_ack) begin
                    state_nx_s = ST_REFILL;
                end else begin
                    state_nx_s = ST_MISS;
                end
            end
            ST_REFILL: state_nx_s = ST_RUN;
            default:   state_nx_s = ST_RUN;
        endcase
    end

    // FSM outputs: the lookup only counts as a hit in RUN; MISS drives the request.
    always_comb begin
        hit_s     = 1'b0;
        mem_req_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                hit_s     = line_valid_s && (line_tag_s == tag_s);
                mem_req_s = 1'b0;
            end
            ST_MISS: begin
                hit_s     = 1'b0;
                mem_req_s = 1'b1;
            end
            ST_REFILL: begin
                hit_s     = 1'b0;
                mem_req_s = 1'b0;
            end
            default: begin
                hit_s     = 1'b0;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // PC and pending-redirect update; redirects seen while not valid win in arrival order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            pend_r     <= 1'b0;
            pend_tgt_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hit_s) begin
                        if (!stall) begin
                            pc_r <= pcSrc ? branch_tgt_s : (pc_r + PC_STEP);
                        end
                    end else if (pcSrc) begin
                        pend_r     <= 1'b1;
                        pend_tgt_r <= branch_tgt_s;
                    end
                end
                ST_MISS: begin
                    if (pcSrc) begin
                        pend_r     <= 1'b1;
                        pend_tgt_r <= branch_tgt_s;
                    end
                end
                ST_REFILL: begin
                    if (pcSrc) begin
                        pc_r <= branch_tgt_s;
                    end else if (pend_r) begin
                        pc_r <= pend_tgt_r;
                    end
                    pend_r <= 1'b0;
                end
                default: begin
                    pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_r;
    assign adderOutput = pc_r + PC_STEP;
    assign instruction = hit_s ? line_data_s : {DATA_W{1'b0}};
    assign valid       = hit_s;
    assign hit         = hit_s;
    assign mem_req     = mem_req_s;
    assign mem_addr    = pc_r & ALIGN_MASK;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Wrapping statistics: consumed hits and RUN-to-MISS transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else begin
            if ((state_r == ST_RUN) && hit_s && !stall) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if ((state_r == ST_RUN) && !hit_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

endmodule
